// File: rtl/mmss_pkg.sv
// Shared constants for the minutes:seconds timer.
package mmss_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;

    // dir encodings
    localparam logic       DIR_UP   = 1'b0;
    localparam logic       DIR_DOWN = 1'b1;

    // sel encodings (adjust target)
    localparam logic       SEL_SEC  = 1'b0;
    localparam logic       SEL_MIN  = 1'b1;

endpackage

// File: rtl/mmss_timer_tick_gen.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled and pulses step
// combinationally in the enabled cycle whose count is DIV-1.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int           CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // step only fires when enabled, so a held (gated) count never steps
    assign step = en && (cnt == LAST);

    // prescaler count: clear wins, otherwise advance and roll over when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end

endmodule

// File: rtl/mmss_timer.sv
// Minutes:seconds up/down timer with optional wrap, per-field adjust and a
// sticky done flag. Single clock; rate control via clock-enable prescalers.
// RUN_DIV and ADJ_DIV must be >= 2 and MIN_MAX < 2**MIN_W.
module mmss_timer
    import mmss_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int ADJ_HZ  = 2,
    parameter int MIN_MAX = 59,
    parameter int MIN_W   = 6,
    parameter int WRAP    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             dir,
    input  logic             adj,
    input  logic             sel,
    output logic [5:0]       seconds,
    output logic [MIN_W-1:0] minutes,
    output logic             done,
    output logic             tick
);

    localparam int               RUN_DIV = CLK_HZ / TICK_HZ;
    localparam int               ADJ_DIV = CLK_HZ / ADJ_HZ;
    localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);
    localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);
    localparam logic [5:0]       SEC_ONE = 6'd1;

    logic             run_en, run_step, adj_step;
    logic [5:0]       sec_n;
    logic [MIN_W-1:0] min_n;
    logic             done_n, tick_n;

    // adjust overrides pause, pause overrides done, done halts the run count
    assign run_en = !adj && !pause && !done;

    tick_gen #(.DIV(RUN_DIV)) u_run (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (adj),
        .step (run_step)
    );

    tick_gen #(.DIV(ADJ_DIV)) u_adj (
        .clk  (clk),
        .rst  (rst),
        .en   (adj),
        .clr  (!adj),
        .step (adj_step)
    );

    // field arithmetic and done handling for adjust and run steps
    always_comb begin
        sec_n  = seconds;
        min_n  = minutes;
        done_n = done;
        tick_n = run_step || adj_step;
        if (adj) begin
            done_n = 1'b0;
            if (adj_step) begin
                if (sel == SEL_MIN)
                    min_n = (minutes == MIN_TOP) ? '0 : minutes + MIN_ONE;
                else
                    sec_n = (seconds == SEC_MAX) ? '0 : seconds + SEC_ONE;
            end
        end else if (run_step) begin
            if (dir == DIR_UP) begin
                if (seconds != SEC_MAX) begin
                    sec_n = seconds + SEC_ONE;
                end else if (minutes != MIN_TOP) begin
                    sec_n = '0;
                    min_n = minutes + MIN_ONE;
                end else if (WRAP != 0) begin
                    sec_n = '0;
                    min_n = '0;
                end else begin
                    // saturate: value held, still counts as an applied step
                    done_n = 1'b1;
                end
            end else begin
                if (seconds == '0 && minutes == '0) begin
                    done_n = 1'b1;
                end else begin
                    if (seconds != '0) begin
                        sec_n = seconds - SEC_ONE;
                    end else begin
                        sec_n = SEC_MAX;
                        min_n = minutes - MIN_ONE;
                    end
                    // landing on 00:00 flags done on the same edge
                    if (seconds == SEC_ONE && minutes == '0)
                        done_n = 1'b1;
                end
            end
        end
    end

    // registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seconds <= '0;
            minutes <= '0;
            done    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            seconds <= sec_n;
            minutes <= min_n;
            done    <= done_n;
            tick    <= tick_n;
        end
    end

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench: two timers (saturating and wrapping) share all inputs.
module tb_mmss_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pause = 1'b0, dir = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [5:0] sec0, sec1;
    logic [1:0] min0, min1;
    logic       done0, done1, tick0, tick1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmss_timer #(.CLK_HZ(10), .TICK_HZ(1), .ADJ_HZ(5), .MIN_MAX(2), .MIN_W(2), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .pause(pause), .dir(dir), .adj(adj), .sel(sel),
        .seconds(sec0), .minutes(min0), .done(done0), .tick(tick0)
    );

    mmss_timer #(.CLK_HZ(10), .TICK_HZ(1), .ADJ_HZ(5), .MIN_MAX(2), .MIN_W(2), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .pause(pause), .dir(dir), .adj(adj), .sel(sel),
        .seconds(sec1), .minutes(min1), .done(done1), .tick(tick1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_sec", sec0, 0);
        chk("rst_min", min0, 0);
        chk("rst_done", done0, 0);
        chk("rst_tick", tick0, 0);
        @(posedge clk); #1 rst = 1'b0;

        // run up: first step exactly 10 cycles after release
        cyc(9);   chk("up_pre_sec", sec0, 0);
        cyc(1);   chk("up_1_sec", sec0, 1);   chk("up_1_tick", tick0, 1);
        cyc(1);   chk("up_tick_low", tick0, 0);
        cyc(589); chk("up_100_min", min0, 1); chk("up_100_sec", sec0, 0);

        // to 02:59 on both
        cyc(1190);
        chk("top_min0", min0, 2); chk("top_sec0", sec0, 59);
        chk("top_min1", min1, 2); chk("top_sec1", sec1, 59);
        cyc(10);
        chk("sat_min", min0, 2); chk("sat_sec", sec0, 59);
        chk("sat_done", done0, 1); chk("sat_tick", tick0, 1);
        chk("wrap_min", min1, 0); chk("wrap_sec", sec1, 0); chk("wrap_done", done1, 0);
        cyc(50);
        chk("hold_min", min0, 2); chk("hold_sec", sec0, 59);
        chk("hold_done", done0, 1); chk("hold_tick", tick0, 0);
        chk("wrap_run_sec", sec1, 5);

        // adjust minutes, 2-cycle steps, mod 3; done clears
        adj = 1'b1; sel = 1'b1;
        cyc(1); chk("adj_done_clr", done0, 0); chk("adj_min0_a", min0, 2);
        cyc(1); chk("adj_min0_1", min0, 0); chk("adj_min1_1", min1, 1);
                chk("adj_sec0", sec0, 59);  chk("adj_sec1", sec1, 5);
        cyc(2); chk("adj_min0_2", min0, 1); chk("adj_min1_2", min1, 2);
        cyc(2); chk("adj_min0_3", min0, 2); chk("adj_min1_3", min1, 0);
        cyc(2); chk("adj_min0_4", min0, 0); chk("adj_min1_4", min1, 1);
                chk("adj_sec1_end", sec1, 5);
        adj = 1'b0; sel = 1'b0;

        // after adjust the run prescaler restarts from 0
        cyc(9); chk("post_adj_hold", sec0, 59);
        cyc(1); chk("post_adj_min", min0, 1); chk("post_adj_sec", sec0, 0);
                chk("post_adj_sec1", sec1, 6);

        // count down from 01:00 to 00:00
        dir = 1'b1;
        cyc(10);  chk("dn_min", min0, 0); chk("dn_sec", sec0, 59); chk("dn_sec1", sec1, 5);
        cyc(580); chk("dn_sec_1", sec0, 1); chk("dn_done_0", done0, 0);
        cyc(10);  chk("dn_zero_sec", sec0, 0); chk("dn_zero_min", min0, 0);
                  chk("dn_zero_done", done0, 1); chk("dn_sec1_b", sec1, 6);
        cyc(20);  chk("dn_hold_sec", sec0, 0); chk("dn_hold_done", done0, 1);
                  chk("dn_sec1_c", sec1, 4);

        // pause in the count-9 cycle blocks that step
        cyc(9); pause = 1'b1;
        cyc(30); chk("pause_sec", sec1, 4); chk("pause_tick", tick1, 0);
        pause = 1'b0;
        cyc(1); chk("unpause_sec", sec1, 3); chk("unpause_tick", tick1, 1);
        cyc(1); chk("unpause_tick_low", tick1, 0);

        // asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("arst_done0", done0, 0); chk("arst_sec1", sec1, 0);
        @(posedge clk); #1 rst = 1'b0; dir = 1'b0;
        cyc(9);   chk("arst_pre", sec1, 0);
        cyc(1);   chk("arst_first", sec1, 1);
        cyc(960); chk("m137_min", min1, 1); chk("m137_sec", sec1, 37);
        #2 rst = 1'b1;
        #1;
        chk("arst2_min", min1, 0); chk("arst2_sec", sec1, 0); chk("arst2_done", done1, 0);
        @(posedge clk); #1 rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
